pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Parametrised hazard controller for the 5-stage MIPS pipeline (F/D/E/M/W). Generates per-stage stall/flush and the four forwarding selects for ID-stage branch compare and EX-stage ALU operands. Adds three things to the previous hazard logic: a multi-cycle MDU busy handshake with a watchdog, an exception-drain state, and correct M-over-W forwarding priority. Sits beside the datapath and is driven by the decode, EX and MEM pipeline registers.

## Interface
- REG_W, 7, register index width; covers GPR plus the extended HI/LO/CP0 indices. Index 0 is never forwarded or matched.
- MDU_MAX_CYC, 40, watchdog limit on MDU busy cycles.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- exc_flush  in  1  one-cycle pulse: exception or eret redirect
- exc_stall  in  1  level: freeze the whole pipeline (cache miss)
- branch_d  in  1  instruction in D is a branch/jump-register
- rs_d, rt_d, rs_e, rt_e  in  REG_W  source indices
- wr_e, wr_m, wr_w  in  REG_W  destination indices
- regwr_e, regwr_m, regwr_w  in  1  stage writes the register file
- memrd_e, memrd_m  in  1  stage holds a load
- mdu_start_e  in  1  multi-cycle mult/div issues in E (one-cycle pulse)
- mdu_done  in  1  MDU result ready
- stall_f, stall_d, stall_e, stall_m, stall_w  out  1
- flush_d, flush_e, flush_m, flush_w  out  1
- fwd_a_d, fwd_b_d  out  2  00 regfile, 01 from E, 10 from M
- fwd_a_e, fwd_b_e  out  2  00 regfile, 01 from W, 10 from M
- mdu_timeout  out  1  one-cycle pulse when the watchdog fires

## Operation
- A source "matches" a stage when the stage's regwr is high, its wr is nonzero and wr equals the source.
- ID forwarding: E match with !memrd_e -> 01, else M match with !memrd_m -> 10, else 00. Loads are never forwarded into D.
- EX forwarding: M match with !memrd_m -> 10 (M has priority), else W match -> 01, else 00.
- Stall/flush are combinational from the current state and the current hazard conditions. Priority, highest first:
  1. exc_stall: every stall high, no flush; state and counter frozen.
  2. exc_flush: flush_d/e/m/w high, no stalls; next state EXC. Any MDU wait is aborted.
  3. state EXC: flush_d, flush_e high for one cycle (drains wrong-path fetch); next state IDLE.
  4. state MDU_BUSY: stall_f/d/e, flush_m. Leave for IDLE on mdu_done, or on the watchdog (pulse mdu_timeout).
  5. branch_d with a load match in E or M: stall_f, stall_d, flush_e. Gives 2 bubbles if the load is in E, 1 if it is in M.
  6. load-use: memrd_e and a load match on rs_d or rt_d: stall_f, stall_d, flush_e for one cycle.
  7. Otherwise all outputs low.
- IDLE + mdu_start_e (and no higher-priority event) -> MDU_BUSY, with the busy counter cleared.
- Busy counter: width clog2(MDU_MAX_CYC+1). It increments each MDU_BUSY cycle and saturates. The watchdog fires when the count reaches MDU_MAX_CYC - 1 and mdu_done is low.
- mdu_done and the watchdog in the same cycle: treat as done, no mdu_timeout.

## Timing
- Forwarding selects: zero latency, pure combinational.
- States: IDLE, MDU_BUSY, EXC. They are registered; all outputs are derived in the same cycle.
- Reset: state IDLE, counters 0. All stall/flush/fwd outputs and mdu_timeout read 0 while rst is high.
- rst mid-MDU: return to IDLE immediately; a late mdu_done is ignored.
- exc_stall while in EXC or MDU_BUSY: the state holds and resumes after release.

## Configuration
- HAZ_PERF_CNT_EN defined: adds outputs perf_load_stall and perf_mdu_stall, each 32 bits. perf_load_stall counts cycles where rule 5 or 6 stalls. perf_mdu_stall counts MDU_BUSY cycles. Both wrap at 2^32 and reset to 0.
- HAZ_PERF_CNT_EN undefined: these ports and registers are absent; all other behaviour is identical.

## Structure
- Shared package haz_pkg holds the state enum (IDLE/MDU_BUSY/EXC), the forwarding-select constants (FWD_RF, FWD_E, FWD_W, FWD_M) and REG_W_DEFAULT.
- One sub-module, haz_fwd_sel: a single-operand forwarding mux decoder, instantiated four times.

## Test plan
- lw $3 in E, add using $3 in D -> one cycle of stall_f/stall_d/flush_e. Next cycle fwd_a_e = 01 with wr_w = 3.
- beq on $5 in D, lw $5 in E -> two stall cycles, then fwd_a_d = 00.
- add $4 in M and add $4 in W, with rs_e = 4 -> fwd_a_e = 10 (M wins).
- mdu_start_e, then mdu_done 10 cycles later -> stall_f/d/e and flush_m for exactly 10 cycles, no mdu_timeout.
- MDU never done, MDU_MAX_CYC = 40 -> mdu_timeout pulses on the 40th busy cycle, then IDLE.
- exc_flush during MDU_BUSY -> flush_d/e/m/w for 1 cycle, then EXC (flush_d/e) for 1 cycle, then IDLE.

Source files
------------

// File: rtl/haz_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller:
// controller state enum and forwarding-select encodings.
package haz_pkg;

  localparam int unsigned REG_W_DEFAULT = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MDU_BUSY = 2'd1,
    EXC      = 2'd2
  } haz_state_e;

  // FWD_E and FWD_W share an encoding: ID muxes read E there, EX muxes read W.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_E  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/haz_fwd_sel.sv
// Single-operand forwarding decoder: picks the nearer producing stage first,
// then the farther one, else the register file. A blocked stage (load) never forwards.
module haz_fwd_sel
  import haz_pkg::*;
#(
  parameter int unsigned REG_W    = REG_W_DEFAULT,
  parameter logic [1:0]  NEAR_SEL = FWD_E,
  parameter logic [1:0]  FAR_SEL  = FWD_M
) (
  input  logic [REG_W-1:0] src,
  input  logic             near_we,
  input  logic [REG_W-1:0] near_wr,
  input  logic             near_blk,
  input  logic             far_we,
  input  logic [REG_W-1:0] far_wr,
  input  logic             far_blk,
  output logic [1:0]       sel
);

  logic near_hit;
  logic far_hit;

  assign near_hit = near_we && !near_blk && (near_wr != '0) && (near_wr == src);
  assign far_hit  = far_we  && !far_blk  && (far_wr  != '0) && (far_wr  == src);

  always_comb begin
    sel = FWD_RF;
    if (near_hit)     sel = NEAR_SEL;
    else if (far_hit) sel = FAR_SEL;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the F/D/E/M/W pipeline: stall/flush, forwarding selects,
// MDU busy wait with watchdog, exception drain. HAZ_PERF_CNT_EN adds stall counters.
module pipeline_hazard_ctrl
  import haz_pkg::*;
#(
  parameter int unsigned REG_W       = REG_W_DEFAULT,
  parameter int unsigned MDU_MAX_CYC = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exc_flush,
  input  logic             exc_stall,
  input  logic             branch_d,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] wr_e,
  input  logic [REG_W-1:0] wr_m,
  input  logic [REG_W-1:0] wr_w,
  input  logic             regwr_e,
  input  logic             regwr_m,
  input  logic             regwr_w,
  input  logic             memrd_e,
  input  logic             memrd_m,
  input  logic             mdu_start_e,
  input  logic             mdu_done,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             stall_w,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic [1:0]       fwd_a_d,
  output logic [1:0]       fwd_b_d,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             mdu_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]      perf_load_stall,
  output logic [31:0]      perf_mdu_stall
`endif
);

  localparam int unsigned    CNT_W    = $clog2(MDU_MAX_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_MAX_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MDU_MAX_CYC);

  haz_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fa_d_raw, fb_d_raw, fa_e_raw, fb_e_raw;
  logic             ld_hit_e, ld_hit_m, load_haz;

  function automatic logic dest_hit(input logic we, input logic [REG_W-1:0] wr,
                                    input logic [REG_W-1:0] src);
    return we && (wr != '0) && (wr == src);
  endfunction

  // A load in E/M whose destination feeds a D-stage source.
  assign ld_hit_e = memrd_e && (dest_hit(regwr_e, wr_e, rs_d) || dest_hit(regwr_e, wr_e, rt_d));
  assign ld_hit_m = memrd_m && (dest_hit(regwr_m, wr_m, rs_d) || dest_hit(regwr_m, wr_m, rt_d));
  assign load_haz = ld_hit_e || (branch_d && ld_hit_m);

  haz_fwd_sel #(.REG_W(REG_W), .NEAR_SEL(FWD_E), .FAR_SEL(FWD_M)) u_fwd_a_d (
    .src(rs_d), .near_we(regwr_e), .near_wr(wr_e), .near_blk(memrd_e),
    .far_we(regwr_m), .far_wr(wr_m), .far_blk(memrd_m), .sel(fa_d_raw));
  haz_fwd_sel #(.REG_W(REG_W), .NEAR_SEL(FWD_E), .FAR_SEL(FWD_M)) u_fwd_b_d (
    .src(rt_d), .near_we(regwr_e), .near_wr(wr_e), .near_blk(memrd_e),
    .far_we(regwr_m), .far_wr(wr_m), .far_blk(memrd_m), .sel(fb_d_raw));
  haz_fwd_sel #(.REG_W(REG_W), .NEAR_SEL(FWD_M), .FAR_SEL(FWD_W)) u_fwd_a_e (
    .src(rs_e), .near_we(regwr_m), .near_wr(wr_m), .near_blk(memrd_m),
    .far_we(regwr_w), .far_wr(wr_w), .far_blk(1'b0), .sel(fa_e_raw));
  haz_fwd_sel #(.REG_W(REG_W), .NEAR_SEL(FWD_M), .FAR_SEL(FWD_W)) u_fwd_b_e (
    .src(rt_e), .near_we(regwr_m), .near_wr(wr_m), .near_blk(memrd_m),
    .far_we(regwr_w), .far_wr(wr_w), .far_blk(1'b0), .sel(fb_e_raw));

  assign fwd_a_d = rst ? FWD_RF : fa_d_raw;
  assign fwd_b_d = rst ? FWD_RF : fb_d_raw;
  assign fwd_a_e = rst ? FWD_RF : fa_e_raw;
  assign fwd_b_e = rst ? FWD_RF : fb_e_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Prioritised stall/flush and next-state decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    stall_w     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    flush_w     = 1'b0;
    mdu_timeout = 1'b0;
    if (!rst) begin
      if (exc_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        stall_w = 1'b1;
      end else if (exc_flush) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
        flush_m = 1'b1;
        flush_w = 1'b1;
        state_d = EXC;
        cnt_d   = '0;
      end else begin
        case (state_q)
          EXC: begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            state_d = IDLE;
          end
          MDU_BUSY: begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
            cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
            // Done wins over a coincident watchdog expiry.
            if (mdu_done) begin
              state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
              mdu_timeout = 1'b1;
              state_d     = IDLE;
            end
          end
          IDLE: begin
            if (load_haz) begin
              stall_f = 1'b1;
              stall_d = 1'b1;
              flush_e = 1'b1;
            end else if (mdu_start_e) begin
              state_d = MDU_BUSY;
              cnt_d   = '0;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic load_stall_c;

  assign load_stall_c = !rst && !exc_stall && !exc_flush && (state_q == IDLE) && load_haz;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_load_stall <= '0;
      perf_mdu_stall  <= '0;
    end else begin
      if (load_stall_c)         perf_load_stall <= perf_load_stall + 32'd1;
      if (state_q == MDU_BUSY)  perf_mdu_stall  <= perf_mdu_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (default build, REG_W=7, MDU_MAX_CYC=40).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_W = 7;

  logic clk = 1'b0;
  logic rst, exc_flush, exc_stall, branch_d;
  logic [REG_W-1:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic regwr_e, regwr_m, regwr_w, memrd_e, memrd_m, mdu_start_e, mdu_done;
  logic stall_f, stall_d, stall_e, stall_m, stall_w;
  logic flush_d, flush_e, flush_m, flush_w;
  logic [1:0] fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
  logic mdu_timeout;
  logic [17:0] obs;

  typedef struct {
    string       tag;
    logic [17:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [4:0] ST_NONE = 5'b00000, ST_LU = 5'b11000, ST_MDU = 5'b11100, ST_ALL = 5'b11111;
  localparam logic [3:0] FL_NONE = 4'b0000, FL_LU = 4'b0100, FL_MDU = 4'b0010;
  localparam logic [3:0] FL_EXC  = 4'b1111, FL_DRAIN = 4'b1100;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .MDU_MAX_CYC(40)) dut (
    .clk(clk), .rst(rst), .exc_flush(exc_flush), .exc_stall(exc_stall), .branch_d(branch_d),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .wr_e(wr_e), .wr_m(wr_m), .wr_w(wr_w),
    .regwr_e(regwr_e), .regwr_m(regwr_m), .regwr_w(regwr_w),
    .memrd_e(memrd_e), .memrd_m(memrd_m), .mdu_start_e(mdu_start_e), .mdu_done(mdu_done),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .mdu_timeout(mdu_timeout));

  always #5 clk = ~clk;

  assign obs = {stall_f, stall_d, stall_e, stall_m, stall_w,
                flush_d, flush_e, flush_m, flush_w,
                fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, mdu_timeout};

  function automatic logic [17:0] mk(input logic [4:0] st, input logic [3:0] fl,
                                     input logic [1:0] fad, input logic [1:0] fbd,
                                     input logic [1:0] fae, input logic [1:0] fbe,
                                     input logic to);
    return {st, fl, fad, fbd, fae, fbe, to};
  endfunction

  task automatic clear_in();
    exc_flush = 1'b0; exc_stall = 1'b0; branch_d = 1'b0;
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    wr_e = '0; wr_m = '0; wr_w = '0;
    regwr_e = 1'b0; regwr_m = 1'b0; regwr_w = 1'b0;
    memrd_e = 1'b0; memrd_m = 1'b0; mdu_start_e = 1'b0; mdu_done = 1'b0;
  endtask

  task automatic drain_sb();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Inputs already driven for this cycle: queue expectation, compare mid-cycle, advance.
  task automatic step(input string tag, input logic [17:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(negedge clk);
    drain_sb();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    // Hazards present during reset must not show on outputs.
    rs_d = 7'd3; wr_e = 7'd3; regwr_e = 1'b1; memrd_e = 1'b1;
    rs_e = 7'd4; wr_m = 7'd4; regwr_m = 1'b1;
    step("reset_outputs", '0);
    rst = 1'b0;
    clear_in();
    step("idle_after_reset", '0);

    // lw $3 in E, add $3 in D
    rs_d = 7'd3; wr_e = 7'd3; regwr_e = 1'b1; memrd_e = 1'b1;
    step("load_use_stall", mk(ST_LU, FL_LU, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    clear_in();
    rs_d = 7'd3; wr_m = 7'd3; regwr_m = 1'b1; memrd_m = 1'b1;
    step("load_in_m_no_stall", '0);
    clear_in();
    rs_e = 7'd3; rt_e = 7'd3; wr_w = 7'd3; regwr_w = 1'b1;
    step("load_use_fwd_w", mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0));

    // beq on $5, lw $5 ahead: two bubbles
    clear_in();
    branch_d = 1'b1; rs_d = 7'd5; wr_e = 7'd5; regwr_e = 1'b1; memrd_e = 1'b1;
    step("branch_load_e", mk(ST_LU, FL_LU, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    clear_in();
    branch_d = 1'b1; rs_d = 7'd5; wr_m = 7'd5; regwr_m = 1'b1; memrd_m = 1'b1;
    step("branch_load_m", mk(ST_LU, FL_LU, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    clear_in();
    branch_d = 1'b1; rs_d = 7'd5; wr_w = 7'd5; regwr_w = 1'b1;
    step("branch_resolved", '0);

    // ID forwarding from ALU results
    clear_in();
    branch_d = 1'b1; rs_d = 7'd6; rt_d = 7'd7;
    wr_e = 7'd6; regwr_e = 1'b1; wr_m = 7'd7; regwr_m = 1'b1;
    step("id_fwd_e_m", mk(ST_NONE, FL_NONE, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0));
    clear_in();
    rs_d = 7'd8; rt_d = 7'd8; wr_e = 7'd8; regwr_e = 1'b1; wr_m = 7'd8; regwr_m = 1'b1;
    step("id_fwd_e_priority", mk(ST_NONE, FL_NONE, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0));

    // EX forwarding: M beats W; load in M falls back to W; index 0 never forwarded
    clear_in();
    rs_e = 7'd4; rt_e = 7'd9; wr_m = 7'd4; regwr_m = 1'b1; wr_w = 7'd4; regwr_w = 1'b1;
    step("ex_fwd_m_wins", mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0));
    rt_e = 7'd4; memrd_m = 1'b1;
    step("ex_fwd_load_m_uses_w", mk(ST_NONE, FL_NONE, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0));
    clear_in();
    wr_m = '0; regwr_m = 1'b1; wr_w = '0; regwr_w = 1'b1; wr_e = '0; regwr_e = 1'b1;
    step("reg0_never_fwd", '0);
    clear_in();
    rs_e = 7'd12; wr_m = 7'd12; regwr_m = 1'b0;
    step("no_regwr_no_fwd", '0);

    // MDU: done on the 10th busy cycle
    clear_in();
    mdu_start_e = 1'b1;
    step("mdu_start", '0);
    clear_in();
    for (int i = 1; i <= 10; i++) begin
      mdu_done = (i == 10);
      step($sformatf("mdu_busy_%0d", i), mk(ST_MDU, FL_MDU, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    end
    clear_in();
    step("mdu_done_idle", '0);

    // MDU never done: watchdog on the 40th busy cycle
    mdu_start_e = 1'b1;
    step("wd_start", '0);
    clear_in();
    for (int i = 1; i <= 40; i++)
      step($sformatf("wd_busy_%0d", i),
           mk(ST_MDU, FL_MDU, 2'b00, 2'b00, 2'b00, 2'b00, (i == 40)));
    step("wd_idle", '0);

    // Done coincident with watchdog: no timeout pulse
    mdu_start_e = 1'b1;
    step("wdd_start", '0);
    clear_in();
    for (int i = 1; i <= 40; i++) begin
      mdu_done = (i == 40);
      step($sformatf("wdd_busy_%0d", i), mk(ST_MDU, FL_MDU, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    end
    clear_in();
    step("wdd_idle", '0);

    // exc_stall freezes the busy counter: timeout slips by the frozen cycles
    mdu_start_e = 1'b1;
    step("frz_start", '0);
    clear_in();
    for (int i = 1; i <= 38; i++)
      step($sformatf("frz_busy_%0d", i), mk(ST_MDU, FL_MDU, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    exc_stall = 1'b1;
    for (int i = 1; i <= 3; i++)
      step($sformatf("frz_stall_%0d", i), mk(ST_ALL, FL_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    exc_stall = 1'b0;
    step("frz_busy_39", mk(ST_MDU, FL_MDU, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    step("frz_busy_40", mk(ST_MDU, FL_MDU, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));
    step("frz_idle", '0);

    // exc_flush aborts MDU wait, then one drain cycle
    mdu_start_e = 1'b1;
    step("exf_start", '0);
    clear_in();
    for (int i = 1; i <= 3; i++)
      step($sformatf("exf_busy_%0d", i), mk(ST_MDU, FL_MDU, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    exc_flush = 1'b1;
    step("exf_flush", mk(ST_NONE, FL_EXC, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    exc_flush = 1'b0;
    step("exf_drain", mk(ST_NONE, FL_DRAIN, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    mdu_done = 1'b1;
    step("exf_idle_late_done", '0);
    clear_in();

    // exc_stall holds EXC, drain resumes after release
    exc_flush = 1'b1;
    step("exs_flush", mk(ST_NONE, FL_EXC, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    exc_flush = 1'b0; exc_stall = 1'b1;
    step("exs_stall", mk(ST_ALL, FL_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    exc_stall = 1'b0;
    step("exs_drain", mk(ST_NONE, FL_DRAIN, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    step("exs_idle", '0);

    // exc_stall outranks exc_flush, and the flush is not taken
    exc_stall = 1'b1; exc_flush = 1'b1;
    step("stall_over_flush", mk(ST_ALL, FL_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    clear_in();
    step("stall_over_flush_idle", '0);

    // rst mid-MDU returns to IDLE; late done ignored
    mdu_start_e = 1'b1;
    step("rst_mdu_start", '0);
    clear_in();
    for (int i = 1; i <= 3; i++)
      step($sformatf("rst_mdu_busy_%0d", i), mk(ST_MDU, FL_MDU, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    rst = 1'b1;
    step("rst_mdu_in_reset", '0);
    rst = 1'b0; mdu_done = 1'b1;
    step("rst_mdu_late_done", '0);
    clear_in();
    step("rst_mdu_idle", '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
